pll_dds_gen: RTL and testbench
==============================

PLL_DDS_GEN -- requirements
Module: pll_dds_gen

Interface
REQ-001 Parameter NUM_CLOCKS, default 2, number of output channels (1..8).
REQ-002 Parameter ACC_W, default 32, phase-accumulator width (4..48).
REQ-003 Parameter LOCK_CYCLES, default 1024, refclk cycles from reset release or last config until locked (>=1).
REQ-004 Parameter DEFAULT_INC, default all zero, NUM_CLOCKS*ACC_W packed reset increments; channel i uses slice [i*ACC_W +: ACC_W].
REQ-005 refclk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cfg_valid  input  1  config request.
REQ-008 cfg_ready  output  1  config accept indication.
REQ-009 cfg_chan  input  max(1,clog2(NUM_CLOCKS))  target channel.
REQ-010 cfg_inc  input  ACC_W  new phase increment.
REQ-011 cfg_phase  input  ACC_W  accumulator load value (phase offset).
REQ-012 cfg_err  output  1  one-cycle pulse: accepted request had an invalid channel.
REQ-013 outclk  output  NUM_CLOCKS  square-wave output per channel (accumulator MSB).
REQ-014 outen  output  NUM_CLOCKS  one-cycle enable pulse per channel on accumulator wrap.
REQ-015 locked  output  1  all channels stable for LOCK_CYCLES cycles.

Function
REQ-016 Each channel SHALL hold registers acc[i] (ACC_W) and inc[i] (ACC_W).
REQ-017 Each cycle without config on channel i: sum = acc[i] + inc[i] at ACC_W+1 bits; acc[i] <= sum[ACC_W-1:0]; outen[i] <= sum[ACC_W].
REQ-018 outclk[i] SHALL equal acc[i][ACC_W-1] taken directly from the register (no combinational logic after the flop).
REQ-019 Output frequency per channel SHALL be f_refclk * inc / 2^ACC_W; inc = 0 freezes the channel (outen 0, outclk constant).
REQ-020 Increment values above 2^(ACC_W-1) SHALL be clamped to 2^(ACC_W-1) at load, for both cfg_inc and DEFAULT_INC.
REQ-021 Handshake: a request is accepted on a rising edge where cfg_valid && cfg_ready.
REQ-022 cfg_ready SHALL be 1 except during rst and in the single cycle after an acceptance (back-to-back accepts impossible).
REQ-023 On acceptance with cfg_chan < NUM_CLOCKS: inc[chan] <= clamped cfg_inc; acc[chan] <= cfg_phase; outen[chan] <= 0. Other channels continue unaffected.
REQ-024 The new inc SHALL first be added on the cycle after acceptance.
REQ-025 On acceptance with cfg_chan >= NUM_CLOCKS: no channel state changes; cfg_err SHALL pulse 1 for the following cycle; the lock counter is not restarted.
REQ-026 cfg_valid while cfg_ready = 0 SHALL be ignored; the requester holds cfg_valid and the payload until accepted.
REQ-027 Lock counter: on rst or on a valid-channel acceptance, it clears and locked <= 0; otherwise it increments, saturating at LOCK_CYCLES.
REQ-028 locked SHALL be 1 exactly when the counter equals LOCK_CYCLES, i.e. LOCK_CYCLES cycles after rst deassertion or acceptance.
REQ-029 Accumulator wrap SHALL be modular, with no saturation and no error flag.

Reset
REQ-030 While rst = 1 at an edge, the block SHALL set: acc[i] = 0, inc[i] = clamped DEFAULT_INC slice, outen = 0, cfg_err = 0, locked = 0, lock counter = 0, cfg_ready = 0.
REQ-031 outclk SHALL be 0 during reset.
REQ-032 rst SHALL override any in-flight config; a request presented in the same cycle as rst is discarded.
REQ-033 cfg_ready SHALL rise in the first cycle after rst deasserts.
REQ-034 Accumulation SHALL start at the first edge with rst = 0.

Verification (bench: NUM_CLOCKS=2, ACC_W=4, LOCK_CYCLES=8, DEFAULT_INC={4'd2,4'd4})
REQ-035 Reset release: outen[0] pulses every 4 cycles and outclk[0] has period 4 (2 high, 2 low); outen[1] pulses every 8 cycles; locked rises 8 cycles after rst falls.
REQ-036 Config ch0 inc=6, phase=0: pattern of 3 outen[0] pulses per 8 cycles; locked drops the cycle after accept and returns 8 cycles later; cfg_ready is low for one cycle; ch1 phase is undisturbed.
REQ-037 Config ch1 inc=12: stored inc = 8; outclk[1] toggles every cycle; outen[1] pulses every 2 cycles.
REQ-038 Config cfg_chan=3: cfg_err is 1 for one cycle; all channels are unchanged; locked remains 1.
REQ-039 cfg_valid held high continuously with alternating payloads: accepts occur only every other cycle; each accepted payload matches the value present at its accept edge.
REQ-040 rst asserted mid-run coincident with cfg_valid: all outputs are at reset values, the request is dropped, and DEFAULT_INC behaviour resumes after release.

Source files
------------

// File: rtl/pll_dds_gen.sv
// Multi-channel DDS clock generator: per-channel phase accumulators clocked by refclk,
// runtime reconfiguration over a valid/ready port, and a lock indicator after settling.
module pll_dds_gen #(
   parameter int NUM_CLOCKS = 2,
   parameter int ACC_W = 32,
   parameter int LOCK_CYCLES = 1024,
   parameter logic [NUM_CLOCKS*ACC_W-1:0] DEFAULT_INC = '0,
   localparam int CHAN_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CHAN_W-1:0]     cfg_chan,
   input  logic [ACC_W-1:0]      cfg_inc,
   input  logic [ACC_W-1:0]      cfg_phase,
   output logic                  cfg_err,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] outen,
   output logic                  locked
);

   localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
   localparam logic [ACC_W-1:0] HALF_INC = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);
   localparam logic [CHAN_W:0] CHAN_LIMIT = (CHAN_W+1)'(NUM_CLOCKS);

   // Increments above half the accumulator range would alias below Nyquist.
   function automatic logic [ACC_W-1:0] clamp_inc(input logic [ACC_W-1:0] v);
      return (v > HALF_INC) ? HALF_INC : v;
   endfunction

   logic             ready_reg;
   logic             err_reg;
   logic [CNT_W-1:0] lock_cnt_reg;
   logic             accept;
   logic             chan_ok;

   assign accept  = cfg_valid && ready_reg;
   assign chan_ok = {1'b0, cfg_chan} < CHAN_LIMIT;

   always_ff @(posedge refclk) begin
      if (rst) begin
         ready_reg    <= 1'b0;
         err_reg      <= 1'b0;
         lock_cnt_reg <= '0;
      end else begin
         ready_reg <= !accept;
         err_reg   <= accept && !chan_ok;
         if (accept && chan_ok)
            lock_cnt_reg <= '0;
         else if (lock_cnt_reg != LOCK_MAX)
            lock_cnt_reg <= lock_cnt_reg + CNT_W'(1);
      end
   end

   assign cfg_ready = ready_reg;
   assign cfg_err   = err_reg;
   assign locked    = (lock_cnt_reg == LOCK_MAX);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
         logic [ACC_W-1:0] acc_reg;
         logic [ACC_W-1:0] inc_reg;
         logic             outen_reg;
         logic [ACC_W:0]   sum;
         logic             hit;

         assign sum = {1'b0, acc_reg} + {1'b0, inc_reg};
         assign hit = accept && chan_ok && (cfg_chan == CHAN_W'(gi));

         always_ff @(posedge refclk) begin
            if (rst) begin
               acc_reg   <= '0;
               inc_reg   <= clamp_inc(DEFAULT_INC[gi*ACC_W +: ACC_W]);
               outen_reg <= 1'b0;
            end else if (hit) begin
               acc_reg   <= cfg_phase;
               inc_reg   <= clamp_inc(cfg_inc);
               outen_reg <= 1'b0;
            end else begin
               acc_reg   <= sum[ACC_W-1:0];
               outen_reg <= sum[ACC_W];
            end
         end

         assign outclk[gi] = acc_reg[ACC_W-1];
         assign outen[gi]  = outen_reg;
      end
   endgenerate

endmodule

// File: tb/tb_pll_dds_gen.sv
// Bench for pll_dds_gen: a 2-channel and a 3-channel instance (the latter so an
// out-of-range channel is representable), checked every cycle against a phase model.
module tb_pll_dds_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid;
   logic [1:0] chan;
   logic [3:0] inc, phase;

   logic       a_ready, a_err, a_locked;
   logic [1:0] a_outclk, a_outen;
   logic       b_ready, b_err, b_locked;
   logic [2:0] b_outclk, b_outen;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pll_dds_gen #(.NUM_CLOCKS(2), .ACC_W(4), .LOCK_CYCLES(8), .DEFAULT_INC(8'h24)) dut_a (
      .refclk(clk), .rst(rst), .cfg_valid(a_valid), .cfg_ready(a_ready),
      .cfg_chan(chan[0]), .cfg_inc(inc), .cfg_phase(phase), .cfg_err(a_err),
      .outclk(a_outclk), .outen(a_outen), .locked(a_locked));

   pll_dds_gen #(.NUM_CLOCKS(3), .ACC_W(4), .LOCK_CYCLES(8), .DEFAULT_INC(12'h124)) dut_b (
      .refclk(clk), .rst(rst), .cfg_valid(b_valid), .cfg_ready(b_ready),
      .cfg_chan(chan), .cfg_inc(inc), .cfg_phase(phase), .cfg_err(b_err),
      .outclk(b_outclk), .outen(b_outen), .locked(b_locked));

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: phase as an integer modulo 16, frequency word clamped to 8.
   int nch[2] = '{2, 3};
   int def_inc[2][3] = '{'{4, 2, 0}, '{4, 2, 1}};
   int m_acc[2][3], m_inc[2][3], m_en[2][3];
   int m_ready[2], m_err[2], m_cnt[2];
   bit m_init = 0;
   int mv, mc, ms;
   bit mok;

   function automatic int clampf(input int v);
      return (v > 8) ? 8 : v;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         mv = (d == 0) ? int'(a_valid) : int'(b_valid);
         mc = (d == 0) ? int'(chan[0]) : int'(chan);
         if (rst) begin
            for (int c = 0; c < 3; c++) begin
               m_acc[d][c] = 0;
               m_inc[d][c] = clampf(def_inc[d][c]);
               m_en[d][c]  = 0;
            end
            m_ready[d] = 0; m_err[d] = 0; m_cnt[d] = 0;
            m_init = 1;
         end else begin
            mok = (mv != 0) && (m_ready[d] != 0);
            m_err[d]   = (mok && mc >= nch[d]) ? 1 : 0;
            m_ready[d] = mok ? 0 : 1;
            for (int c = 0; c < nch[d]; c++) begin
               if (mok && mc == c) begin
                  m_inc[d][c] = clampf(int'(inc));
                  m_acc[d][c] = int'(phase);
                  m_en[d][c]  = 0;
               end else begin
                  ms = m_acc[d][c] + m_inc[d][c];
                  m_en[d][c]  = (ms >= 16) ? 1 : 0;
                  m_acc[d][c] = ms % 16;
               end
            end
            if (mok && mc < nch[d]) m_cnt[d] = 0;
            else if (m_cnt[d] < 8)  m_cnt[d]++;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         for (int c = 0; c < 2; c++) begin
            check($sformatf("a_outclk%0d", c), int'(a_outclk[c]), (m_acc[0][c] >= 8) ? 1 : 0);
            check($sformatf("a_outen%0d", c), int'(a_outen[c]), m_en[0][c]);
         end
         for (int c = 0; c < 3; c++) begin
            check($sformatf("b_outclk%0d", c), int'(b_outclk[c]), (m_acc[1][c] >= 8) ? 1 : 0);
            check($sformatf("b_outen%0d", c), int'(b_outen[c]), m_en[1][c]);
         end
         check("a_ready", int'(a_ready), m_ready[0]);
         check("a_err", int'(a_err), m_err[0]);
         check("a_locked", int'(a_locked), (m_cnt[0] == 8) ? 1 : 0);
         check("b_ready", int'(b_ready), m_ready[1]);
         check("b_err", int'(b_err), m_err[1]);
         check("b_locked", int'(b_locked), (m_cnt[1] == 8) ? 1 : 0);
      end
   end

   int   w_en0, w_en1, w_tog1, w_rdylow;
   logic w_lock_pre, w_lock_last;

   // Observe dut_a for n cycles from the current falling edge.
   task automatic window(input int n);
      logic prev;
      prev = a_outclk[1];
      w_en0 = 0; w_en1 = 0; w_tog1 = 0; w_rdylow = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         w_en0 += int'(a_outen[0]);
         w_en1 += int'(a_outen[1]);
         if (a_outclk[1] != prev) w_tog1++;
         prev = a_outclk[1];
         if (!a_ready) w_rdylow++;
         if (i == n - 2) w_lock_pre = a_locked;
         if (i == n - 1) w_lock_last = a_locked;
      end
   endtask

   // Present a request and hold it until accepted; returns at the falling edge after acceptance.
   task automatic send(input bit to_b, input logic [1:0] c, input logic [3:0] i_v, input logic [3:0] p_v);
      int tries;
      @(negedge clk);
      chan = c; inc = i_v; phase = p_v;
      if (to_b) b_valid = 1'b1; else a_valid = 1'b1;
      tries = 0;
      while (((to_b ? b_ready : a_ready) !== 1'b1) && tries < 10) begin
         @(negedge clk);
         tries++;
      end
      check("accept_wait", (tries < 10) ? 1 : 0, 1);
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      $display("tx: dut%s chan=%0d inc=%0d phase=%0d accepted", to_b ? "b" : "a", c, i_v, p_v);
   endtask

   initial begin
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; chan = '0; inc = '0; phase = '0;
      repeat (3) @(negedge clk);
      check("rst_outclk", int'(a_outclk), 0);
      check("rst_ready", int'(a_ready), 0);
      check("rst_locked", int'(a_locked), 0);
      rst = 1'b0;
      $display("tx: reset release");

      window(8);
      check("rel_outen0_pulses", w_en0, 2);
      check("rel_outen1_pulses", w_en1, 1);
      check("rel_lock_at7", int'(w_lock_pre), 0);
      check("rel_lock_at8", int'(w_lock_last), 1);

      send(1'b0, 2'd0, 4'd6, 4'd0);
      check("cfg0_locked_drop", int'(a_locked), 0);
      check("cfg0_ready_low", int'(a_ready), 0);
      window(8);
      check("cfg0_outen0_pulses", w_en0, 3);
      check("cfg0_ready_low_after", w_rdylow, 0);
      check("cfg0_lock_at7", int'(w_lock_pre), 0);
      check("cfg0_lock_at8", int'(w_lock_last), 1);

      send(1'b0, 2'd1, 4'd12, 4'd0);
      window(8);
      check("cfg1_outen1_pulses", w_en1, 4);
      check("cfg1_outclk1_toggles", w_tog1, 8);

      send(1'b1, 2'd3, 4'd5, 4'd5);
      check("badch_err_pulse", int'(b_err), 1);
      check("badch_locked_kept", int'(b_locked), 1);
      @(negedge clk);
      check("badch_err_clear", int'(b_err), 0);
      check("badch_locked_still", int'(b_locked), 1);

      // Held valid with a payload changing every cycle: accepts on alternate edges.
      a_valid = 1'b1;
      w_rdylow = 0;
      for (int k = 0; k < 8; k++) begin
         chan = 2'd0; inc = (k % 2 == 1) ? 4'd3 : 4'd5; phase = 4'(k);
         @(negedge clk);
         if (!a_ready) w_rdylow++;
         $display("tx: held valid k=%0d inc=%0d phase=%0d ready_after=%0d", k, inc, phase, a_ready);
      end
      a_valid = 1'b0;
      check("b2b_ready_low_cycles", w_rdylow, 4);
      check("b2b_last_outclk0", int'(a_outclk[0]), 1);

      rst = 1'b1; a_valid = 1'b1; chan = 2'd1; inc = 4'd1; phase = 4'd5;
      @(negedge clk);
      check("mid_rst_outclk", int'(a_outclk), 0);
      check("mid_rst_outen", int'(a_outen), 0);
      check("mid_rst_locked", int'(a_locked), 0);
      check("mid_rst_ready", int'(a_ready), 0);
      rst = 1'b0; a_valid = 1'b0;
      $display("tx: mid-run reset with request pending");
      window(8);
      check("mid_rel_outen0_pulses", w_en0, 2);
      check("mid_rel_outen1_pulses", w_en1, 1);
      check("mid_rel_lock_at8", int'(w_lock_last), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
